// File: rtl/vga_frame_sequencer.sv
// vga_frame_sequencer
// Frame/scene sequencer for the VGA demo datapath. Detects vsync rising edges
// in the clk domain, advances a frame counter (speed divider, direction, pause,
// single-step) and hands frame/mode values to the pixel datapath through a
// valid/ready commit so they stay constant across a visible frame.
//
// Ports:
//   clk, rst_n       pixel clock, synchronous active-low reset
//   vsync_i          registered active-high vsync
//   btn_pause_i      asynchronous pause/resume button
//   btn_step_i       asynchronous single-step button
//   speed_i[1:0]     one advance every 2^speed frames
//   dir_i            0 = increment, 1 = decrement
//   upd_ready_i      datapath accepts the pending update
//   upd_valid_o      an update is pending
//   frame_o          committed frame counter
//   zoom_mode_o, mode_a_o, mode_b_o   committed mode bits
//   frame_tick_o     one-cycle pulse when a commit becomes visible
//   paused_o         high in PAUSED and STEP_ARM
//
// Build option: define SEQ_DEBOUNCE_EN to debounce the buttons on vsync edges.
//
// state    | meaning
// PLAY     | counter advances through the speed divider
// PAUSED   | counter frozen, waiting for resume or step
// STEP_ARM | one advance scheduled on the next vsync edge
module vga_frame_sequencer #(
    parameter int FRAME_W         = 12,
    parameter int RESET_FRAME     = 300,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vsync_i,
    input  logic               btn_pause_i,
    input  logic               btn_step_i,
    input  logic [1:0]         speed_i,
    input  logic               dir_i,
    input  logic               upd_ready_i,
    output logic               upd_valid_o,
    output logic [FRAME_W-1:0] frame_o,
    output logic               zoom_mode_o,
    output logic               mode_a_o,
    output logic               mode_b_o,
    output logic               frame_tick_o,
    output logic               paused_o
);

    typedef enum logic [1:0] {PLAY, PAUSED, STEP_ARM} state_t;

    localparam logic [FRAME_W-1:0] RST_F = FRAME_W'(RESET_FRAME);

    state_t             state_q, state_d;
    logic               vs_q, vs_rise;
    logic [1:0]         sync1_q, sync2_q, btn_lvl, btn_prev_q, btn_ev;
    logic [2:0]         div_q, div_d, div_lim;
    logic               count, advance, commit;
    logic [FRAME_W-1:0] pending_q, pending_d;
    logic               upd_valid_d;

    assign vs_rise = vsync_i & ~vs_q;

`ifdef SEQ_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    logic [1:0]    db_lvl_q;
    logic [CW-1:0] db_cnt_q [2];

    // Level flips only after DEBOUNCE_FRAMES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_lvl_q    <= '0;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
        end else if (vs_rise) begin
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] != db_lvl_q[i]) begin
                    if (db_cnt_q[i] == CW'(DEBOUNCE_FRAMES - 1)) begin
                        db_lvl_q[i] <= sync2_q[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + CW'(1);
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    assign btn_lvl = db_lvl_q;
`else
    assign btn_lvl = sync2_q;
`endif

    // bit 0 = pause, bit 1 = step
    assign btn_ev = btn_lvl & ~btn_prev_q;

    always_comb begin
        case (speed_i)
            2'd0:    div_lim = 3'd0;
            2'd1:    div_lim = 3'd1;
            2'd2:    div_lim = 3'd3;
            default: div_lim = 3'd7;
        endcase
    end

    always_comb begin
        state_d = state_q;
        count   = 1'b0;
        advance = 1'b0;
        div_d   = div_q;
        case (state_q)
            PLAY: begin
                // A pause event wins over a coincident vsync edge.
                if (btn_ev[0]) state_d = PAUSED;
                else           count   = vs_rise;
            end
            PAUSED: begin
                if (btn_ev[0]) begin
                    state_d = PLAY;
                    count   = vs_rise;
                end else if (btn_ev[1]) begin
                    state_d = STEP_ARM;
                end
            end
            STEP_ARM: begin
                if (btn_ev[0]) begin
                    state_d = PLAY;
                    count   = vs_rise;
                end else if (vs_rise) begin
                    advance = 1'b1;
                    state_d = PAUSED;
                end
            end
            default: state_d = PLAY;
        endcase
        // >= keeps a lowered speed from waiting out a full wrap of div_q.
        if (count) begin
            if (div_q >= div_lim) begin
                advance = 1'b1;
                div_d   = 3'd0;
            end else begin
                div_d = div_q + 3'd1;
            end
        end
    end

    assign commit = upd_valid_o & upd_ready_i;

    always_comb begin
        pending_d   = pending_q;
        upd_valid_d = upd_valid_o;
        if (advance) begin
            pending_d   = dir_i ? pending_q - FRAME_W'(1) : pending_q + FRAME_W'(1);
            upd_valid_d = 1'b1;
        end else if (commit) begin
            upd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_q         <= 1'b0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            btn_prev_q   <= '0;
            state_q      <= PLAY;
            div_q        <= 3'd0;
            pending_q    <= RST_F;
            upd_valid_o  <= 1'b0;
            frame_o      <= RST_F;
            zoom_mode_o  <= RST_F[7] & RST_F[8];
            mode_a_o     <= RST_F[8];
            mode_b_o     <= RST_F[7] ^ RST_F[8];
            frame_tick_o <= 1'b0;
            paused_o     <= 1'b0;
        end else begin
            vs_q         <= vsync_i;
            sync1_q      <= {btn_step_i, btn_pause_i};
            sync2_q      <= sync1_q;
            btn_prev_q   <= btn_lvl;
            state_q      <= state_d;
            div_q        <= div_d;
            pending_q    <= pending_d;
            upd_valid_o  <= upd_valid_d;
            frame_tick_o <= commit;
            paused_o     <= (state_d != PLAY);
            if (commit) begin
                frame_o     <= pending_q;
                zoom_mode_o <= pending_q[7] & pending_q[8];
                mode_a_o    <= pending_q[8];
                mode_b_o    <= pending_q[7] ^ pending_q[8];
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_sequencer.sv
module tb_vga_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0, bp = 1'b0, bs = 1'b0;
    logic [1:0]  speed = 2'd0;
    logic        dir = 1'b0, ready = 1'b1;
    logic        upd_valid, zoom, ma, mb, tick, paused;
    logic [11:0] frame;

    int vectors = 0, miscompares = 0, ticks = 0, t0, model_f = 300;
    int sb[$];

    vga_frame_sequencer dut (
        .clk(clk), .rst_n(rst_n), .vsync_i(vsync), .btn_pause_i(bp), .btn_step_i(bs),
        .speed_i(speed), .dir_i(dir), .upd_ready_i(ready), .upd_valid_o(upd_valid),
        .frame_o(frame), .zoom_mode_o(zoom), .mode_a_o(ma), .mode_b_o(mb),
        .frame_tick_o(tick), .paused_o(paused)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        repeat (3) step();
    endtask

    function automatic int nxt(input int f, input logic d);
        return d ? (f + 4095) % 4096 : (f + 1) % 4096;
    endfunction

    task automatic push_adv();
        model_f = nxt(model_f, dir);
        sb.push_back(model_f);
    endtask

    task automatic press_pause();
        bp = 1'b1;
        repeat (4) step();
        bp = 1'b0;
        repeat (3) step();
    endtask

    // Scoreboard: every commit must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && tick === 1'b1) begin
            int e;
            logic [11:0] p;
            ticks++;
            chk("tick_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                p = 12'(e);
                chk("sb_frame", 32'(frame), 32'(e));
                chk("sb_zoom", 32'(zoom), 32'(p[7] & p[8]));
                chk("sb_mode_a", 32'(ma), 32'(p[8]));
                chk("sb_mode_b", 32'(mb), 32'(p[7] ^ p[8]));
            end
        end
    end

    initial begin
        // reset values
        repeat (3) step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_frame", 32'(frame), 32'd300);
        chk("rst_mode_a", 32'(ma), 32'd1);
        chk("rst_mode_b", 32'(mb), 32'd1);
        chk("rst_zoom", 32'(zoom), 32'd0);
        chk("rst_valid", 32'(upd_valid), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_paused", 32'(paused), 32'd0);
        step();

        // first pulse with exact latency
        vsync = 1'b1;
        push_adv();
        step();
        vsync = 1'b0;
        @(negedge clk);
        chk("lat_valid_n1", 32'(upd_valid), 32'd1);
        chk("lat_tick_n1", 32'(tick), 32'd0);
        chk("lat_frame_n1", 32'(frame), 32'd300);
        step();
        @(negedge clk);
        chk("lat_tick_n2", 32'(tick), 32'd1);
        chk("lat_frame_n2", 32'(frame), 32'd301);
        chk("lat_valid_n2", 32'(upd_valid), 32'd0);
        step();
        @(negedge clk);
        chk("tick_width", 32'(tick), 32'd0);
        step();
        for (int i = 0; i < 2; i++) begin
            push_adv();
            pulse();
        end
        chk("speed0_frame", 32'(frame), 32'd303);

        // speed 2: one advance per 4 pulses
        speed = 2'd2;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) push_adv();
            pulse();
        end
        chk("speed2_frame", 32'(frame), 32'd304);
        repeat (3) pulse();
        chk("speed2_hold", 32'(frame), 32'd304);
        speed = 2'd0;
        push_adv();
        pulse();
        chk("speed_drop", 32'(frame), 32'd305);

        // coalescing with ready low
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            model_f = nxt(model_f, dir);
            pulse();
        end
        chk("coal_valid", 32'(upd_valid), 32'd1);
        chk("coal_frame_held", 32'(frame), 32'd305);
        t0 = ticks;
        sb.push_back(model_f);
        ready = 1'b1;
        repeat (4) step();
        chk("coal_frame", 32'(frame), 32'd308);
        chk("coal_ticks", 32'(ticks - t0), 32'd1);
        chk("coal_valid_low", 32'(upd_valid), 32'd0);

`ifdef SEQ_DEBOUNCE_EN
        // two-frame glitch on pause must not change state
        bp = 1'b1;
        repeat (3) step();
        push_adv();
        pulse();
        push_adv();
        pulse();
        bp = 1'b0;
        repeat (3) step();
        for (int i = 0; i < 4; i++) begin
            push_adv();
            pulse();
        end
        chk("glitch_paused", 32'(paused), 32'd0);
        chk("glitch_frame", 32'(frame), 32'(model_f));
`else
        // pause latency: state changes on the third edge
        bp = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("pause_lat_early", 32'(paused), 32'd0);
        step();
        @(negedge clk);
        chk("pause_lat", 32'(paused), 32'd1);
        bp = 1'b0;
        repeat (3) step();
        repeat (5) pulse();
        chk("paused_frame", 32'(frame), 32'(model_f));
        chk("paused_valid", 32'(upd_valid), 32'd0);

        // single step, second step press while armed is ignored
        bs = 1'b1;
        repeat (4) step();
        bs = 1'b0;
        repeat (3) step();
        chk("step_arm_paused", 32'(paused), 32'd1);
        bs = 1'b1;
        repeat (4) step();
        bs = 1'b0;
        repeat (3) step();
        push_adv();
        pulse();
        chk("step_frame", 32'(frame), 32'(model_f));
        chk("step_paused", 32'(paused), 32'd1);
        pulse();
        chk("step_not_queued", 32'(frame), 32'(model_f));

        // resume, then pause coincident with vs_rise: no advance
        press_pause();
        chk("resume_paused", 32'(paused), 32'd0);
        bp = 1'b1;
        step();
        step();
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        bp = 1'b0;
        repeat (3) step();
        chk("coinc_paused", 32'(paused), 32'd1);
        chk("coinc_frame", 32'(frame), 32'(model_f));
        chk("coinc_valid", 32'(upd_valid), 32'd0);
        press_pause();
        push_adv();
        pulse();
        chk("resume_adv", 32'(frame), 32'(model_f));
`endif

        // reset mid-operation discards the pending update
        ready = 1'b0;
        pulse();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        model_f = 300;
        @(negedge clk);
        chk("midrst_valid", 32'(upd_valid), 32'd0);
        chk("midrst_frame", 32'(frame), 32'd300);
        step();

        // decrement through wrap: 301 pulses from 300
        ready = 1'b1;
        dir = 1'b1;
        for (int i = 0; i < 301; i++) begin
            push_adv();
            pulse();
        end
        chk("wrap_frame", 32'(frame), 32'd4095);
        chk("wrap_zoom", 32'(zoom), 32'd1);
        chk("wrap_mode_a", 32'(ma), 32'd1);
        chk("wrap_mode_b", 32'(mb), 32'd0);

        repeat (4) step();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_frame_sequencer.md
# vga_frame_sequencer

Frame and scene sequencer for the VGA demo datapath. It replaces clocking the frame counter directly off `posedge vsync`: it detects vsync rising edges in the `clk` domain, advances a frame counter with selectable speed, direction, pause and single-step, and decodes the scene-mode bits. New values reach the pixel datapath through a valid/ready commit handshake, so `frame` and the mode bits stay constant for the whole visible frame.

## Interface
- `FRAME_W`, 12: frame counter width.
- `RESET_FRAME`, 300: counter value loaded at reset.
- `DEBOUNCE_FRAMES`, 4: number of consecutive stable vsync samples required when debounce is compiled in.

- `clk` in 1: pixel clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `vsync` in 1: registered active-high vsync from the sync generator.
- `btn_pause` in 1: asynchronous pause/resume button.
- `btn_step` in 1: asynchronous single-step button.
- `speed` in 2: one advance every 2^speed frames.
- `dir` in 1: 0 = increment, 1 = decrement.
- `upd_ready` in 1: datapath accepts the pending update.
- `upd_valid` out 1: an update is pending.
- `frame` out FRAME_W: committed frame counter.
- `zoom_mode`, `mode_a`, `mode_b` out 1 each: committed mode bits.
- `frame_tick` out 1: one-cycle pulse on the cycle a commit becomes visible.
- `paused` out 1: high in PAUSED and STEP_ARM.

## Operation
- **vsync edge:** `vs_q <= vsync`; `vs_rise = vsync & ~vs_q`. `vs_q` resets to 0.
- **Buttons:** each passes through a 2-flop synchronizer (reset 0). A press event is a rising edge of the synchronized level, or of the debounced level when debounce is enabled.
- **States:** PLAY, PAUSED, STEP_ARM. Reset state is PLAY.
  - PLAY + pause event -> PAUSED.
  - PAUSED + pause event -> PLAY.
  - PAUSED + step event -> STEP_ARM.
  - STEP_ARM + `vs_rise` -> advance by exactly one, bypassing the divider, then -> PAUSED.
  - STEP_ARM + pause event -> PLAY; the step is cancelled.
  - Step events in PLAY or STEP_ARM are ignored. Steps are not queued.
- **Divider:** `div_cnt` has width 3 and resets to 0. On each `vs_rise` in PLAY:
  - if `div_cnt >= (1<<speed)-1`: advance and clear `div_cnt`;
  - else increment `div_cnt`.
  - Using `>=` makes a mid-count reduction of `speed` safe.
  - `div_cnt` holds its value while paused.
- **Advance:** `pending <= pending ± 1` according to `dir`, wrapping modulo 2^FRAME_W (0 - 1 = 4095; 4095 + 1 = 0). `upd_valid <= 1`.
- **Commit:** when `upd_valid & upd_ready`:
  - `frame <= pending`;
  - `zoom_mode <= p[7]&p[8]`, `mode_a <= p[8]`, `mode_b <= p[7]^p[8]`, where p = pending;
  - `frame_tick <= 1`;
  - `upd_valid <= 0`, unless a new advance occurs in the same cycle, in which case it stays 1 with the new pending value.
- **Coalescing:** an advance while `upd_valid` is still high overwrites `pending`. Only the latest value is committed and no intermediate value is emitted.
- **Simultaneous pause event and `vs_rise`:** the state transition is evaluated first.
  - PLAY -> PAUSED: no advance and no divider update.
  - PAUSED -> PLAY: the `vs_rise` counts toward the divider.
- **Reset values:**
  - `frame = pending = RESET_FRAME`;
  - mode bits decoded from RESET_FRAME; for 300: `mode_a = 1`, `mode_b = 1`, `zoom_mode = 0`;
  - `upd_valid = 0`, `frame_tick = 0`, `paused = 0`, `div_cnt = 0`;
  - debounce counters 0, debounced levels 0.
- **Reset mid-operation:** any pending update is discarded.

## Timing
- Cycle N: `vsync = 1`, `vs_q = 0` → `vs_rise`.
- N+1: `upd_valid = 1`.
- If `upd_ready = 1` at N+1: at N+2 `frame`, mode bits and `frame_tick` update and `upd_valid = 0`.
- Minimum latency from `vs_rise` to a visible update is 2 cycles. With `upd_ready` low, `upd_valid` holds indefinitely.
- `frame_tick` is high for exactly one cycle per commit.
- Button-to-state latency: 3 cycles (2 synchronizer flops + edge register) when debounce is disabled.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `SEQ_DEBOUNCE_EN` defined:
  - each synchronized button is sampled only on `vs_rise`;
  - the debounced level changes after DEBOUNCE_FRAMES consecutive equal samples that differ from the current level;
  - any disagreeing sample restarts the count.
- `SEQ_DEBOUNCE_EN` undefined: the debounce logic is absent and events come straight from synchronized edges.

## Test plan
- Reset, `speed = 0`, `dir = 0`, `upd_ready = 1`, 3 vsync pulses → `frame` 301, 302, 303; one `frame_tick` per pulse, 2 cycles after each `vs_rise`.
- `speed = 2` → one advance per 4 vsync pulses. Switching to `speed = 0` while `div_cnt = 3` → advance on the next pulse.
- `dir = 1`, 301 pulses from 300 → `frame = 4095`. Mode bits for 4095: `zoom_mode = 1`, `mode_a = 1`, `mode_b = 0`.
- Hold `upd_ready = 0` for 3 advances, then raise it → a single commit to 303 and a single `frame_tick`.
- Pause, then 5 vsync pulses → `frame` unchanged. Then step → +1 at the next `vs_rise` and `paused` stays 1. Step while in STEP_ARM → ignored.
- Pause event in the same cycle as `vs_rise` in PLAY → no advance. With `SEQ_DEBOUNCE_EN`, a 2-frame glitch on `btn_pause` → no state change.
